ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter IW, default 9: instruction width; opcode is instr[IW-1:IW-6].
REQ-002 Parameter CNTW, default 16: retired-instruction counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  leave IDLE/HALT and begin fetching.
REQ-006 instr, instr_valid  in  IW, 1  fetched word and its qualifier.
REQ-007 alu_c, alu_z  in  1, 1  ALU carry-out and zero result of the current EXEC cycle.
REQ-008 mem_ack  in  1  data-memory completion.
REQ-009 fetch_req, mem_req  out  1, 1  instruction fetch request and data-memory request.
REQ-010 sel_a_mux, sel_b_mux, sel_gd_b_mux, sel_bit_mux, sel_shift_mux, shift_dir, shift_mode, alu_sel_out[2:0], reg_in_sel, reg_alu_dat_sel, dat_in_sel  out  datapath selects.
REQ-011 reg_wr_en, dat_wr_en, pc_inc, pc_jmp_en, pc_jmp_abs  out  1 each  single-cycle strobes.
REQ-012 busy, done, retired[CNTW-1:0], state[2:0]  out  status.

Function
REQ-013 States: IDLE=0, FETCH=1, EXEC=2, MEM=3, HALT=4, driven on state.
REQ-014 IDLE: start -> FETCH; otherwise hold.
REQ-015 FETCH: fetch_req=1; instr_valid=1 latches instr into IR and moves to EXEC; otherwise hold.
REQ-016 Datapath selects decode from IR only in EXEC and MEM; all selects and strobes are 0 in every other state.
REQ-017 Opcode map: 000??? cmp; 001??? mov; 01000? add; 01001? sub; 01010? lsl; 01011? rol; 01100? and; 01101? or; 01110? xor; 10000? jge; 10001? jg; 10010? jmp; 101000 inc; 101001 lsl1; 101010 rol1; 101011 clr; 101100 not; 101101/110000 ldr; 101110/110001 str; 111111 halt; all others nop.
REQ-018 ALU selects: add/sub/cmp/inc alu_sel_out=100 (sub/cmp: sel_b_mux=1, sel_bit_mux=1; inc: sel_bit_mux=1, sel_gd_b_mux=1); shifts/rotates 101 (rol: shift_mode=1; lsl1/rol1: sel_shift_mux=1); and 001; or 010; xor 011; clr 001 with sel_gd_b_mux=1; not 110 with sel_a_mux=1.
REQ-019 EXEC, ALU ops other than cmp: reg_wr_en=1; mov: reg_wr_en=1, reg_in_sel=1; cmp: reg_wr_en=0.
REQ-020 EXEC, cmp/add/sub: latch flags C<=alu_c, Z<=alu_z; all other opcodes leave flags unchanged.
REQ-021 Branch taken: jmp always; jge when C=1; jg when C=1 and Z=0; flags used are those latched before this EXEC cycle.
REQ-022 Taken branch: pc_jmp_en=1, pc_jmp_abs=0, pc_inc=0; every other non-halt, non-memory EXEC: pc_inc=1; exactly one of pc_inc/pc_jmp_en per retired instruction.
REQ-023 EXEC next state: ldr/str -> MEM; halt -> HALT with no pc strobe; otherwise -> FETCH.
REQ-024 MEM: ldr reg_wr_en=1, reg_alu_dat_sel=1; str dat_wr_en=1, dat_in_sel=1; strobes and pc_inc for one cycle only, on the completing cycle (REQ-034/035); then -> FETCH.
REQ-025 retired increments by 1 on every EXEC exit to FETCH and every MEM completion; halt does not count; saturates at all-ones, never wraps.
REQ-026 HALT: done=1; start -> FETCH, clears done, retired held; reset is the only way to clear retired.
REQ-027 busy=1 in FETCH, EXEC, MEM; 0 in IDLE, HALT.
REQ-028 start outside IDLE/HALT is ignored.

Reset
REQ-029 reset asserted: immediately state=IDLE, IR=0, C=Z=0, retired=0, done=0.
REQ-030 While in reset and after release: all selects, strobes, fetch_req, mem_req, busy = 0.
REQ-031 Reset mid-FETCH/EXEC/MEM aborts the instruction; no strobe emitted in the reset cycle and it is not counted.

Configuration
REQ-032 Macro CTRL_MEM_HANDSHAKE_EN selects the memory timing.
REQ-033 mem_req=1 throughout MEM when defined; 0 always when undefined.
REQ-034 Defined: MEM holds until mem_ack=1; strobes of REQ-024 assert only in the mem_ack cycle; mem_ack outside MEM ignored.
REQ-035 Undefined: MEM lasts exactly one cycle with strobes asserted; mem_ack ignored.

Verification
REQ-036 reset, start, instr=9'b010000_000 (add) valid -> EXEC cycle: alu_sel_out=100, reg_wr_en=1, pc_inc=1; retired=1 after.
REQ-037 cmp with alu_c=1, alu_z=0, then jg -> jg EXEC: pc_jmp_en=1, pc_inc=0; repeat with alu_z=1 -> pc_inc=1.
REQ-038 Handshake defined: ldr, mem_ack held low 3 cycles then high -> state MEM 4 cycles, reg_wr_en exactly one pulse with the ack.
REQ-039 Handshake undefined: str -> MEM 1 cycle, dat_wr_en=1 once, mem_req=0.
REQ-040 halt -> state=4, done=1, busy=0, retired unchanged; start -> FETCH, done=0.
REQ-041 CNTW=2, retire 5 instructions -> retired=3; reset asserted mid-EXEC -> all outputs 0 in same cycle.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
//------------------------------------------------------------------------------
// ctrl_sequencer_if
// Bundles the control sequencer's fetch, flag, memory-handshake, datapath-select
// and status signals. Signal suffixes are from the sequencer's point of view.
// The master modport is the sequencer; the slave modport is its environment.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ctrl_sequencer_if #(
    parameter int IW   = 9,
    parameter int CNTW = 16
);
    // Environment -> sequencer
    logic            start_i;
    logic [IW-1:0]   instr_i;
    logic            instr_valid_i;
    logic            alu_c_i;
    logic            alu_z_i;
    logic            mem_ack_i;

    // Requests
    logic            fetch_req_o;
    logic            mem_req_o;

    // Datapath selects
    logic            sel_a_mux_o;
    logic            sel_b_mux_o;
    logic            sel_gd_b_mux_o;
    logic            sel_bit_mux_o;
    logic            sel_shift_mux_o;
    logic            shift_dir_o;
    logic            shift_mode_o;
    logic [2:0]      alu_sel_out_o;
    logic            reg_in_sel_o;
    logic            reg_alu_dat_sel_o;
    logic            dat_in_sel_o;

    // Single-cycle strobes
    logic            reg_wr_en_o;
    logic            dat_wr_en_o;
    logic            pc_inc_o;
    logic            pc_jmp_en_o;
    logic            pc_jmp_abs_o;

    // Status
    logic            busy_o;
    logic            done_o;
    logic [CNTW-1:0] retired_o;
    logic [2:0]      state_o;

    modport master (
        input  start_i, instr_i, instr_valid_i, alu_c_i, alu_z_i, mem_ack_i,
        output fetch_req_o, mem_req_o,
        output sel_a_mux_o, sel_b_mux_o, sel_gd_b_mux_o, sel_bit_mux_o,
        output sel_shift_mux_o, shift_dir_o, shift_mode_o, alu_sel_out_o,
        output reg_in_sel_o, reg_alu_dat_sel_o, dat_in_sel_o,
        output reg_wr_en_o, dat_wr_en_o, pc_inc_o, pc_jmp_en_o, pc_jmp_abs_o,
        output busy_o, done_o, retired_o, state_o
    );

    modport slave (
        output start_i, instr_i, instr_valid_i, alu_c_i, alu_z_i, mem_ack_i,
        input  fetch_req_o, mem_req_o,
        input  sel_a_mux_o, sel_b_mux_o, sel_gd_b_mux_o, sel_bit_mux_o,
        input  sel_shift_mux_o, shift_dir_o, shift_mode_o, alu_sel_out_o,
        input  reg_in_sel_o, reg_alu_dat_sel_o, dat_in_sel_o,
        input  reg_wr_en_o, dat_wr_en_o, pc_inc_o, pc_jmp_en_o, pc_jmp_abs_o,
        input  busy_o, done_o, retired_o, state_o
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
//------------------------------------------------------------------------------
// ctrl_sequencer
// Instruction sequencer: IDLE -> FETCH -> EXEC [-> MEM] -> FETCH ... -> HALT.
// Decodes the 6-bit opcode held in IR into datapath selects and strobes,
// keeps carry/zero flags for conditional branches, and counts retired
// instructions in a saturating counter.
// Optional feature macro: CTRL_MEM_HANDSHAKE_EN -- when defined, MEM drives
// mem_req and waits for mem_ack; otherwise MEM always lasts one cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_sequencer #(
    parameter int IW   = 9,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ctrl_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    typedef enum logic [4:0] {
        OP_NOP, OP_CMP, OP_MOV, OP_ADD, OP_SUB, OP_LSL, OP_ROL, OP_AND,
        OP_OR, OP_XOR, OP_JGE, OP_JG, OP_JMP, OP_INC, OP_LSL1, OP_ROL1,
        OP_CLR, OP_NOT, OP_LDR, OP_STR, OP_HALT
    } op_e;

    state_e          state_q, state_d;
    logic [5:0]      ir_q;          // only the opcode field of IR is ever consumed
    logic            c_q, z_q;
    logic [CNTW-1:0] retired_q, retired_d;

    op_e             op;
    logic            ir_we;
    logic            flags_we;
    logic            retire;
    logic            mem_done;
    logic            taken;

    // MEM completion: either the acknowledge or unconditionally after one cycle
`ifdef CTRL_MEM_HANDSHAKE_EN
    assign mem_done      = bus.mem_ack_i;
    assign bus.mem_req_o = (state_q == S_MEM);
`else
    assign mem_done      = 1'b1;
    assign bus.mem_req_o = 1'b0;
`endif

    // Opcode decode of the latched instruction
    always_comb begin
        op = OP_NOP;
        casez (ir_q)
            6'b000???: op = OP_CMP;
            6'b001???: op = OP_MOV;
            6'b01000?: op = OP_ADD;
            6'b01001?: op = OP_SUB;
            6'b01010?: op = OP_LSL;
            6'b01011?: op = OP_ROL;
            6'b01100?: op = OP_AND;
            6'b01101?: op = OP_OR;
            6'b01110?: op = OP_XOR;
            6'b10000?: op = OP_JGE;
            6'b10001?: op = OP_JG;
            6'b10010?: op = OP_JMP;
            6'b101000: op = OP_INC;
            6'b101001: op = OP_LSL1;
            6'b101010: op = OP_ROL1;
            6'b101011: op = OP_CLR;
            6'b101100: op = OP_NOT;
            6'b101101,
            6'b110000: op = OP_LDR;
            6'b101110,
            6'b110001: op = OP_STR;
            6'b111111: op = OP_HALT;
            default:   op = OP_NOP;
        endcase
    end

    // Branch resolution uses the flags latched by earlier instructions
    assign taken = (op == OP_JMP) ||
                   ((op == OP_JGE) && c_q) ||
                   ((op == OP_JG)  && c_q && !z_q);

    // Datapath selects, decoded from IR only while an instruction is in flight
    always_comb begin
        bus.sel_a_mux_o       = 1'b0;
        bus.sel_b_mux_o       = 1'b0;
        bus.sel_gd_b_mux_o    = 1'b0;
        bus.sel_bit_mux_o     = 1'b0;
        bus.sel_shift_mux_o   = 1'b0;
        bus.shift_dir_o       = 1'b0;
        bus.shift_mode_o      = 1'b0;
        bus.alu_sel_out_o     = 3'b000;
        bus.reg_in_sel_o      = 1'b0;
        bus.reg_alu_dat_sel_o = 1'b0;
        bus.dat_in_sel_o      = 1'b0;
        if ((state_q == S_EXEC) || (state_q == S_MEM)) begin
            case (op)
                OP_ADD:  bus.alu_sel_out_o = 3'b100;
                OP_SUB, OP_CMP: begin
                    bus.alu_sel_out_o = 3'b100;
                    bus.sel_b_mux_o   = 1'b1;
                    bus.sel_bit_mux_o = 1'b1;
                end
                OP_INC: begin
                    bus.alu_sel_out_o  = 3'b100;
                    bus.sel_bit_mux_o  = 1'b1;
                    bus.sel_gd_b_mux_o = 1'b1;
                end
                OP_LSL:  bus.alu_sel_out_o = 3'b101;
                OP_ROL: begin
                    bus.alu_sel_out_o = 3'b101;
                    bus.shift_mode_o  = 1'b1;
                end
                OP_LSL1: begin
                    bus.alu_sel_out_o   = 3'b101;
                    bus.sel_shift_mux_o = 1'b1;
                end
                OP_ROL1: begin
                    bus.alu_sel_out_o   = 3'b101;
                    bus.shift_mode_o    = 1'b1;
                    bus.sel_shift_mux_o = 1'b1;
                end
                OP_AND:  bus.alu_sel_out_o = 3'b001;
                OP_OR:   bus.alu_sel_out_o = 3'b010;
                OP_XOR:  bus.alu_sel_out_o = 3'b011;
                OP_CLR: begin
                    bus.alu_sel_out_o  = 3'b001;
                    bus.sel_gd_b_mux_o = 1'b1;
                end
                OP_NOT: begin
                    bus.alu_sel_out_o = 3'b110;
                    bus.sel_a_mux_o   = 1'b1;
                end
                OP_MOV:  bus.reg_in_sel_o      = 1'b1;
                OP_LDR:  bus.reg_alu_dat_sel_o = 1'b1;
                OP_STR:  bus.dat_in_sel_o      = 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state, strobes and bookkeeping enables
    always_comb begin
        state_d          = state_q;
        ir_we            = 1'b0;
        flags_we         = 1'b0;
        retire           = 1'b0;
        bus.fetch_req_o  = 1'b0;
        bus.reg_wr_en_o  = 1'b0;
        bus.dat_wr_en_o  = 1'b0;
        bus.pc_inc_o     = 1'b0;
        bus.pc_jmp_en_o  = 1'b0;
        bus.pc_jmp_abs_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.fetch_req_o = 1'b1;
                if (bus.instr_valid_i) begin
                    ir_we   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                flags_we = (op == OP_CMP) || (op == OP_ADD) || (op == OP_SUB);
                case (op)
                    OP_ADD, OP_SUB, OP_LSL, OP_ROL, OP_AND, OP_OR, OP_XOR,
                    OP_INC, OP_LSL1, OP_ROL1, OP_CLR, OP_NOT, OP_MOV:
                        bus.reg_wr_en_o = 1'b1;
                    default: ;
                endcase
                if ((op == OP_LDR) || (op == OP_STR)) begin
                    state_d = S_MEM;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d          = S_FETCH;
                    retire           = 1'b1;
                    bus.pc_jmp_en_o  = taken;
                    bus.pc_inc_o     = !taken;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    bus.reg_wr_en_o = (op == OP_LDR);
                    bus.dat_wr_en_o = (op == OP_STR);
                    bus.pc_inc_o    = 1'b1;
                    retire          = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_HALT: begin
                if (bus.start_i) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating retired-instruction count
    always_comb begin
        retired_d = retired_q;
        if (retire && (retired_q != {CNTW{1'b1}})) retired_d = retired_q + CNTW'(1);
    end

    // State, IR, flags and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= 6'd0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            if (ir_we) ir_q <= bus.instr_i[IW-1:IW-6];
            if (flags_we) begin
                c_q <= bus.alu_c_i;
                z_q <= bus.alu_z_i;
            end
        end
    end

    assign bus.state_o   = state_q;
    assign bus.busy_o    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign bus.done_o    = (state_q == S_HALT);
    assign bus.retired_o = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
//------------------------------------------------------------------------------
// tb_ctrl_sequencer
// Directed opening sequences followed by randomized stimulus, compared every
// cycle against an instruction-level reference model. A second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_sequencer;
    localparam int IW = 9;
`ifdef CTRL_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] instr = '0;
    logic          valid = 1'b0;
    logic          alu_c = 1'b0;
    logic          alu_z = 1'b0;
    logic          mem_ack = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_sequencer_if #(.IW(IW), .CNTW(16)) bus ();
    ctrl_sequencer_if #(.IW(IW), .CNTW(2))  bus2 ();

    assign bus.start_i        = start;
    assign bus.instr_i        = instr;
    assign bus.instr_valid_i  = valid;
    assign bus.alu_c_i        = alu_c;
    assign bus.alu_z_i        = alu_z;
    assign bus.mem_ack_i      = mem_ack;
    assign bus2.start_i       = start;
    assign bus2.instr_i       = instr;
    assign bus2.instr_valid_i = valid;
    assign bus2.alu_c_i       = alu_c;
    assign bus2.alu_z_i       = alu_z;
    assign bus2.mem_ack_i     = mem_ack;

    ctrl_sequencer #(.IW(IW), .CNTW(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
    ctrl_sequencer #(.IW(IW), .CNTW(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // Reference model: architectural phase (0..4), opcode, flags, retire count
    int m_st  = 0;
    int m_op  = 0;
    bit m_c   = 1'b0;
    bit m_z   = 1'b0;
    int m_ret = 0;

    bit [5:0] pick [9] = '{6'd45, 6'd48, 6'd46, 6'd49, 6'd63, 6'd32, 6'd34, 6'd36, 6'd0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string opname(input int op);
        int hi3 = op / 8;
        int hi5 = op / 2;
        if (hi3 == 0) return "cmp";
        if (hi3 == 1) return "mov";
        case (hi5)
            8: return "add";   9: return "sub";  10: return "lsl";  11: return "rol";
            12: return "and"; 13: return "or";   14: return "xor";
            16: return "jge"; 17: return "jg";   18: return "jmp";
            default: ;
        endcase
        case (op)
            40: return "inc";  41: return "lsl1"; 42: return "rol1"; 43: return "clr";
            44: return "not";  45, 48: return "ldr"; 46, 49: return "str";
            63: return "halt";
            default: ;
        endcase
        return "nop";
    endfunction

    function automatic bit writes_reg(input string n);
        return (n == "add") || (n == "sub") || (n == "lsl") || (n == "rol") ||
               (n == "and") || (n == "or")  || (n == "xor") || (n == "inc") ||
               (n == "lsl1") || (n == "rol1") || (n == "clr") || (n == "not") ||
               (n == "mov");
    endfunction

    // Expected selects {a,b,gd_b,bit,shift,dir,mode,alu[2:0],reg_in,reg_alu_dat,dat_in}
    // and strobes {reg_wr,dat_wr,pc_inc,pc_jmp_en,pc_jmp_abs}
    task automatic expected(output logic [12:0] sels, output logic [4:0] strb);
        string n = opname(m_op);
        bit a = 0, b = 0, gd = 0, bt = 0, sh = 0, sm = 0, ris = 0, rad = 0, din = 0;
        bit [2:0] alu = 3'd0;
        bit wr = 0, dw = 0, inc = 0, jmp = 0, tk;
        if (m_st == 2 || m_st == 3) begin
            case (n)
                "add":  alu = 3'd4;
                "sub", "cmp": begin alu = 3'd4; b = 1; bt = 1; end
                "inc":  begin alu = 3'd4; bt = 1; gd = 1; end
                "lsl":  alu = 3'd5;
                "rol":  begin alu = 3'd5; sm = 1; end
                "lsl1": begin alu = 3'd5; sh = 1; end
                "rol1": begin alu = 3'd5; sm = 1; sh = 1; end
                "and":  alu = 3'd1;
                "or":   alu = 3'd2;
                "xor":  alu = 3'd3;
                "clr":  begin alu = 3'd1; gd = 1; end
                "not":  begin alu = 3'd6; a = 1; end
                "mov":  ris = 1;
                "ldr":  rad = 1;
                "str":  din = 1;
                default: ;
            endcase
        end
        if (m_st == 2) begin
            tk = (n == "jmp") || (n == "jge" && m_c) || (n == "jg" && m_c && !m_z);
            wr = writes_reg(n);
            if (tk) jmp = 1;
            else if (n != "halt" && n != "ldr" && n != "str") inc = 1;
        end
        if (m_st == 3 && (!HS || mem_ack)) begin
            inc = 1;
            wr  = (n == "ldr");
            dw  = (n == "str");
        end
        sels = {a, b, gd, bt, sh, 1'b0, sm, alu, ris, rad, din};
        strb = {wr, dw, inc, jmp, 1'b0};
    endtask

    function automatic logic [12:0] dut_sels();
        return {bus.sel_a_mux_o, bus.sel_b_mux_o, bus.sel_gd_b_mux_o, bus.sel_bit_mux_o,
                bus.sel_shift_mux_o, bus.shift_dir_o, bus.shift_mode_o, bus.alu_sel_out_o,
                bus.reg_in_sel_o, bus.reg_alu_dat_sel_o, bus.dat_in_sel_o};
    endfunction

    function automatic logic [4:0] dut_strb();
        return {bus.reg_wr_en_o, bus.dat_wr_en_o, bus.pc_inc_o, bus.pc_jmp_en_o, bus.pc_jmp_abs_o};
    endfunction

    task automatic check_outputs();
        logic [12:0] es;
        logic [4:0]  et;
        expected(es, et);
        check_eq("state",     32'(bus.state_o), 32'(m_st));
        check_eq("busy",      32'(bus.busy_o), 32'(m_st >= 1 && m_st <= 3));
        check_eq("done",      32'(bus.done_o), 32'(m_st == 4));
        check_eq("fetch_req", 32'(bus.fetch_req_o), 32'(m_st == 1));
        check_eq("mem_req",   32'(bus.mem_req_o), 32'(HS && m_st == 3));
        check_eq("selects",   32'(dut_sels()), 32'(es));
        check_eq("strobes",   32'(dut_strb()), 32'(et));
        check_eq("retired",   32'(bus.retired_o), 32'((m_ret > 65535) ? 65535 : m_ret));
        check_eq("retired_w2", 32'(bus2.retired_o), 32'((m_ret > 3) ? 3 : m_ret));
        check_eq("state_w2",  32'(bus2.state_o), 32'(m_st));
    endtask

    task automatic model_step();
        string n;
        case (m_st)
            0: if (start) m_st = 1;
            1: if (valid) begin m_op = int'(instr[IW-1:IW-6]); m_st = 2; end
            2: begin
                n = opname(m_op);
                if (n == "cmp" || n == "add" || n == "sub") begin m_c = alu_c; m_z = alu_z; end
                if (n == "ldr" || n == "str") m_st = 3;
                else if (n == "halt") m_st = 4;
                else begin m_st = 1; m_ret++; end
            end
            3: if (!HS || mem_ack) begin m_st = 1; m_ret++; end
            4: if (start) m_st = 1;
            default: m_st = 0;
        endcase
    endtask

    task automatic model_reset();
        m_st = 0; m_op = 0; m_c = 0; m_z = 0; m_ret = 0;
    endtask

    // One clock: apply inputs, check at the falling edge, advance the model
    task automatic cycle(input bit s, input bit [5:0] op, input bit v,
                         input bit c, input bit z, input bit a);
        start = s; instr = {op, 3'($urandom_range(0, 7))}; valid = v;
        alu_c = c; alu_z = z; mem_ack = a;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_outs", 32'({dut_sels(), dut_strb(), bus.fetch_req_o, bus.mem_req_o,
                                  bus.busy_o, bus.done_o, bus.state_o}), 32'd0);
        check_eq("rst_retired", 32'(bus.retired_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_eq("por_state", 32'(bus.state_o), 32'd0);
        check_eq("por_outs", 32'({dut_sels(), dut_strb(), bus.fetch_req_o, bus.busy_o,
                                  bus.done_o, bus.retired_o}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // add: IDLE -> FETCH -> EXEC -> FETCH
        cycle(1, 6'b010000, 0, 0, 0, 0);
        cycle(0, 6'b010000, 1, 0, 0, 0);
        cycle(0, 6'b000000, 0, 0, 0, 0);
        check_eq("add_retired", 32'(bus.retired_o), 32'd1);

        // cmp (C=1,Z=0) then jg taken; cmp (C=1,Z=1) then jg not taken
        for (int k = 0; k < 2; k++) begin
            cycle(0, 6'b000000, 1, 0, 0, 0);
            cycle(0, 6'b000000, 0, 1, (k == 1), 0);
            cycle(0, 6'b100010, 1, 0, 0, 0);
            cycle(0, 6'b000000, 0, 0, 0, 0);
        end

        // ldr with ack held low for three cycles, then str with immediate ack
        cycle(0, 6'b101101, 1, 0, 0, 1);
        cycle(0, 6'b000000, 0, 0, 0, 1);
        repeat (3) cycle(0, 6'b000000, 0, 0, 0, 0);
        cycle(0, 6'b000000, 0, 0, 0, 1);
        cycle(0, 6'b101110, 1, 0, 0, 0);
        cycle(0, 6'b000000, 0, 0, 0, 1);
        cycle(0, 6'b000000, 0, 0, 0, 1);

        // halt, linger, restart
        cycle(0, 6'b111111, 1, 0, 0, 0);
        cycle(0, 6'b000000, 0, 0, 0, 0);
        cycle(0, 6'b000000, 0, 0, 0, 0);
        cycle(1, 6'b000000, 0, 0, 0, 0);
        cycle(0, 6'b000000, 0, 0, 0, 0);

        // reset while an add is in EXEC
        cycle(0, 6'b010000, 1, 0, 0, 0);
        pulse_reset();
        cycle(0, 6'b000000, 0, 0, 0, 0);

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            bit [5:0] op;
            if ($urandom_range(0, 2) == 0) op = pick[$urandom_range(0, 8)];
            else op = 6'($urandom_range(0, 63));
            cycle($urandom_range(0, 3) == 0, op, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 249) == 0) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
